// File: rtl/uart_pkt_parser_if.sv
// Rx FIFO read port plus payload byte stream of the UART packet parser.
// master = parser side, slave = FIFO/downstream side.
interface uart_pkt_parser_if #(
  parameter int W_DATA = 8
);
  logic              rx_empty;
  logic [W_DATA-1:0] rx_data;
  logic              rd_uart;
  logic [W_DATA-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    input  rx_empty, rx_data, m_ready,
    output rd_uart, m_data, m_valid, m_last
  );

  modport slave (
    output rx_empty, rx_data, m_ready,
    input  rd_uart, m_data, m_valid, m_last
  );
endinterface

// File: rtl/uart_pkt_parser.sv
// Frames the Rx FIFO byte stream into SOF/LEN/payload/CHK packets and streams the payload out.
// Define UART_PKT_TIMEOUT_EN to enable the inter-byte timeout (tmo_err); otherwise tmo_err is 0.
module uart_pkt_parser #(
  parameter int              W_DATA      = 8,
  parameter logic [W_DATA-1:0] SOF       = W_DATA'('hA5),
  parameter int              MAX_LEN     = 64,
  parameter int              W_CNT       = 16,
  parameter int              TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_pkt_parser_if.master  bus,
  output logic               pkt_ok,
  output logic               pkt_err,
  output logic               len_err,
  output logic               tmo_err,
  output logic               busy,
  output logic [W_CNT-1:0]   pkt_cnt,
  output logic [W_CNT-1:0]   err_cnt
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK} state_t;

  state_t            state, state_nxt;
  logic [W_DATA-1:0] acc_p1, m_data_p1, b, chk_sum;
  logic [LEN_W-1:0]  rem_p1;
  logic              vld_p1, last_p1;
  logic              pop, load, tmo_hit;
  logic              ok_nxt, perr_nxt, lerr_nxt;

  function automatic logic [W_CNT-1:0] sat_inc(input logic [W_CNT-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign b = bus.rx_data;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (pop) begin
      case (state)
        S_HUNT:    if (b == SOF) state_nxt = S_LEN;
        S_LEN: begin
          if (b > W_DATA'(MAX_LEN)) state_nxt = S_HUNT;
          else if (b == '0)         state_nxt = S_CHK;
          else                      state_nxt = S_PAYLOAD;
        end
        S_PAYLOAD: if (rem_p1 == LEN_W'(1)) state_nxt = S_CHK;
        S_CHK:     state_nxt = S_HUNT;
        default:   state_nxt = S_HUNT;
      endcase
    end
    if (tmo_hit) state_nxt = S_HUNT;
  end

  // The FIFO is only back-pressured while a payload byte is stuck in the output register.
  always_comb begin
    busy     = (state != S_HUNT);
    pop      = !bus.rx_empty && !(state == S_PAYLOAD && vld_p1 && !bus.m_ready);
    load     = pop && (state == S_PAYLOAD);
    chk_sum  = acc_p1 + b;
    ok_nxt   = pop && (state == S_CHK) && (chk_sum == '0);
    perr_nxt = pop && (state == S_CHK) && (chk_sum != '0);
    lerr_nxt = pop && (state == S_LEN) && (b > W_DATA'(MAX_LEN));
  end

  assign bus.rd_uart = pop;
  assign bus.m_data  = m_data_p1;
  assign bus.m_valid = vld_p1;
  assign bus.m_last  = last_p1;

  // Stage p1: accumulator, remaining count, payload register, status pulses, counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_p1    <= '0;
      rem_p1    <= '0;
      m_data_p1 <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      pkt_ok    <= 1'b0;
      pkt_err   <= 1'b0;
      len_err   <= 1'b0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      if (pop && state == S_LEN) begin
        acc_p1 <= b;
        rem_p1 <= LEN_W'(b);
      end else if (load) begin
        acc_p1 <= acc_p1 + b;
        rem_p1 <= rem_p1 - 1'b1;
      end
      if (load) begin
        m_data_p1 <= b;
        vld_p1    <= 1'b1;
        last_p1   <= (rem_p1 == LEN_W'(1));
      end else if (bus.m_ready) begin
        vld_p1    <= 1'b0;
      end
      pkt_ok  <= ok_nxt;
      pkt_err <= perr_nxt;
      len_err <= lerr_nxt;
      if (ok_nxt) pkt_cnt <= sat_inc(pkt_cnt);
      if (perr_nxt || lerr_nxt || tmo_hit) err_cnt <= sat_inc(err_cnt);
    end
  end

`ifdef UART_PKT_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] tmr_p1;

  assign tmo_hit = busy && bus.rx_empty && (tmr_p1 == TMR_W'(TIMEOUT_CYC));

  // Timer only advances while a packet is open and the FIFO has nothing for us.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr_p1  <= '0;
      tmo_err <= 1'b0;
    end else begin
      tmo_err <= tmo_hit;
      if (pop || !busy || tmo_hit) tmr_p1 <= '0;
      else if (bus.rx_empty)       tmr_p1 <= tmr_p1 + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo_err = 1'b0;
`endif
endmodule
